credit_pipe_fifo: RTL and testbench



---
 rtl/credit_pipe_fifo_pkg.sv | 25 ++
 rtl/credit_pipe_fifo_mem.sv | 33 +++
 rtl/credit_pipe_fifo.sv | 154 +++++++++++++++
 tb/tb_credit_pipe_fifo.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/credit_pipe_fifo_pkg.sv
// ---------------------------------------------------------------------------
// credit_pipe_fifo_pkg
// Shared definitions for the credit-tracked receive FIFO: default depth,
// controller state encoding and a constant-evaluable ceil(log2) helper.
// ---------------------------------------------------------------------------
package credit_pipe_fifo_pkg;

  localparam int CREDIT_PIPE_DEPTH_DEFAULT = 16;

  typedef enum logic {
    CPF_DRAIN = 1'b0,
    CPF_RUN   = 1'b1
  } cpf_state_e;

  // ceil(log2(value)); returns 0 for value <= 1.
  function automatic int cpf_clog2(input int value);
    int res;
    res = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) res = i + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/credit_pipe_fifo_mem.sv
// ---------------------------------------------------------------------------
// credit_pipe_fifo_mem
// Simple dual-port storage: one synchronous write port, one asynchronous
// read port. No reset on the array so it can map onto small LUT RAM.
//   clk       : clock
//   wr_en_i   : write strobe
//   wr_addr_i : write address
//   wr_data_i : write data
//   rd_addr_i : read address
//   rd_data_o : read data (combinational from rd_addr_i)
// ---------------------------------------------------------------------------
module credit_pipe_fifo_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic [AW-1:0]    rd_addr_i,
  output logic [WIDTH-1:0] rd_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/credit_pipe_fifo.sv
// ---------------------------------------------------------------------------
// credit_pipe_fifo
// Receive FIFO behind a fixed-latency pipe that cannot stall. Each launch
// into the pipe reserves a slot (credit), so arrivals always find room.
// After reset the block drains for PIPE_LATENCY cycles, ignoring arrivals,
// so stale pipe contents are flushed.
//
// state     | meaning
// ----------+------------------------------------------------------------
// CPF_DRAIN | flushing pipe; no issue allowed, arrivals ignored, no errors
// CPF_RUN   | normal operation
//
// Ports:
//   clk, rst      : clock, synchronous active-low reset
//   issueReady    : upstream may launch an item this cycle
//   issue         : upstream launches an item
//   dataInValid   : pipe output valid
//   dataIn        : pipe output payload
//   dataOutValid  : FIFO non-empty
//   dataOut       : head entry
//   dataOutReady  : consumer takes the head
//   occupancy     : stored entries
//   credits       : stored entries plus items in flight
//   creditError   : sticky, issue seen while not ready
//   overflowError : sticky, push while full or arrival without credit
// ---------------------------------------------------------------------------
module credit_pipe_fifo
  import credit_pipe_fifo_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int DEPTH        = CREDIT_PIPE_DEPTH_DEFAULT,
  parameter int PIPE_LATENCY = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic                      issueReady,
  input  logic                      issue,
  input  logic                      dataInValid,
  input  logic [WIDTH-1:0]          dataIn,
  output logic                      dataOutValid,
  output logic [WIDTH-1:0]          dataOut,
  input  logic                      dataOutReady,
  output logic [cpf_clog2(DEPTH):0] occupancy,
  output logic [cpf_clog2(DEPTH):0] credits,
  output logic                      creditError,
  output logic                      overflowError
);

  localparam int AW = cpf_clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int DW = cpf_clog2(PIPE_LATENCY) + 1;
  localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(PIPE_LATENCY - 1);

  cpf_state_e    state_q, state_d;
  logic [DW-1:0] drain_cnt_q, drain_cnt_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] occ_q, occ_d;
  logic [CW-1:0] cred_q, cred_d;
  logic          cerr_q, cerr_d;
  logic          oerr_q, oerr_d;
  logic          issue_ready_q, issue_ready_d;
  logic          out_valid_q, out_valid_d;

  logic run;
  logic pop;
  logic issue_ok;
  logic push_req;
  logic push;
  logic full;
  logic no_credit;
  logic cred_dec;

  assign run       = (state_q == CPF_RUN);
  assign pop       = out_valid_q & dataOutReady;
  assign issue_ok  = issue & issue_ready_q;
  assign push_req  = dataInValid & run;
  assign full      = (occ_q == DEPTH_C);
  // Nothing in flight: any arrival now was never paid for by a credit.
  assign no_credit = (cred_q == occ_q);
  // A pop on a full FIFO frees the slot the same-cycle write lands in.
  assign push      = push_req & (~full | pop);
  // Guard only matters after an unpaid arrival has broken occupancy <= credits.
  assign cred_dec  = pop & (cred_q != '0);

  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    if (state_q == CPF_DRAIN) begin
      if (drain_cnt_q == DRAIN_LAST) state_d = CPF_RUN;
      else drain_cnt_d = drain_cnt_q + DW'(1);
    end

    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    occ_d    = occ_q + CW'(push) - CW'(pop);
    cred_d   = cred_q + CW'(issue_ok) - CW'(cred_dec);

    cerr_d = cerr_q | (issue & ~issue_ready_q & run);
    oerr_d = oerr_q | (push_req & ((full & ~pop) | no_credit));

    // Registered so issueReady reflects the credit count after this edge.
    issue_ready_d = (state_d == CPF_RUN) && (cred_d < DEPTH_C);
    out_valid_d   = (occ_d != '0);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= CPF_DRAIN;
      drain_cnt_q   <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      occ_q         <= '0;
      cred_q        <= '0;
      cerr_q        <= 1'b0;
      oerr_q        <= 1'b0;
      issue_ready_q <= 1'b0;
      out_valid_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      drain_cnt_q   <= drain_cnt_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      occ_q         <= occ_d;
      cred_q        <= cred_d;
      cerr_q        <= cerr_d;
      oerr_q        <= oerr_d;
      issue_ready_q <= issue_ready_d;
      out_valid_q   <= out_valid_d;
    end
  end

  credit_pipe_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk       (clk),
    .wr_en_i   (push),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (dataIn),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (dataOut)
  );

  assign issueReady    = issue_ready_q;
  assign dataOutValid  = out_valid_q;
  assign occupancy     = occ_q;
  assign credits       = cred_q;
  assign creditError   = cerr_q;
  assign overflowError = oerr_q;

endmodule

// File: tb/tb_credit_pipe_fifo.sv
// ---------------------------------------------------------------------------
// tb_credit_pipe_fifo
// Bench for credit_pipe_fifo with an upstream fixed-latency pipe model,
// a queue-based reference model and directed plus random stimulus.
// ---------------------------------------------------------------------------
module tb_credit_pipe_fifo;

  localparam int W  = 8;
  localparam int D  = 16;
  localparam int PL = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         issueReady;
  logic         issue = 1'b0;
  logic [W-1:0] issue_data = '0;
  logic         dataInValid;
  logic [W-1:0] dataIn;
  logic         dataOutValid;
  logic [W-1:0] dataOut;
  logic         dataOutReady = 1'b0;
  logic [4:0]   occupancy;
  logic [4:0]   credits;
  logic         creditError;
  logic         overflowError;

  logic         force_div  = 1'b0;
  logic [W-1:0] force_data = '0;

  always #5 clk = ~clk;

  credit_pipe_fifo #(
    .WIDTH        (W),
    .DEPTH        (D),
    .PIPE_LATENCY (PL)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .issueReady    (issueReady),
    .issue         (issue),
    .dataInValid   (dataInValid),
    .dataIn        (dataIn),
    .dataOutValid  (dataOutValid),
    .dataOut       (dataOut),
    .dataOutReady  (dataOutReady),
    .occupancy     (occupancy),
    .credits       (credits),
    .creditError   (creditError),
    .overflowError (overflowError)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Upstream pipe (no reset, like a real shift-register chain) plus reference model.
  logic [PL-1:0] pv = '0;
  logic [W-1:0]  pd [PL];

  assign dataInValid = pv[PL-1] | force_div;
  assign dataIn      = force_div ? force_data : pd[PL-1];

  logic [W-1:0] m_q [$];
  int  m_credits = 0;
  int  m_drain   = PL;
  bit  m_run     = 0;
  bit  m_ready   = 0;
  bit  m_cerr    = 0;
  bit  m_oerr    = 0;
  bit  m_pop, m_push, m_ok;

  always @(posedge clk) begin
    pv    <= {pv[PL-2:0], issue && m_ready};
    pd[0] <= issue_data;
    for (int i = 1; i < PL; i++) pd[i] <= pd[i-1];

    if (!rst) begin
      m_q.delete();
      m_credits = 0;
      m_drain   = PL;
      m_run     = 0;
      m_cerr    = 0;
      m_oerr    = 0;
    end else begin
      m_pop  = (m_q.size() != 0) && dataOutReady;
      m_ok   = issue && m_ready;
      m_push = 0;
      if (m_run && issue && !m_ready) m_cerr = 1;
      if (m_run && dataInValid) begin
        if (m_credits == m_q.size()) m_oerr = 1;
        if (m_q.size() == D && !m_pop) m_oerr = 1;
        else m_push = 1;
      end
      if (m_pop) void'(m_q.pop_front());
      if (m_push) m_q.push_back(dataIn);
      if (m_ok) m_credits++;
      if (m_pop && m_credits > 0) m_credits--;
      if (!m_run) begin
        m_drain--;
        if (m_drain == 0) m_run = 1;
      end
    end
    m_ready = m_run && (m_credits < D);
  end

  bit chk_en = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("issueReady", issueReady, m_ready);
      chk("dataOutValid", dataOutValid, m_q.size() != 0);
      chk("occupancy", occupancy, m_q.size());
      chk("credits", credits, m_credits);
      chk("creditError", creditError, m_cerr);
      chk("overflowError", overflowError, m_oerr);
      if (m_q.size() != 0) chk("dataOut", dataOut, m_q[0]);
    end
  end

  int drain_cycles, rdy_cnt, exp_idx, max_cred;
  bit done;

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk_en = 1;
    chk("rst_issueReady", issueReady, 0);
    chk("rst_dataOutValid", dataOutValid, 0);
    chk("rst_occupancy", occupancy, 0);
    chk("rst_credits", credits, 0);
    chk("rst_creditError", creditError, 0);
    chk("rst_overflowError", overflowError, 0);

    // Drain: count cycles with issueReady low after release, pulse arrivals
    rst = 1'b1;
    drain_cycles = 0;
    done = 0;
    for (int k = 0; k < 20 && !done; k++) begin
      if (k > 0) @(negedge clk);
      if (issueReady) done = 1;
      else begin
        drain_cycles++;
        force_div  = (k == 1) || (k == 2);
        force_data = 8'h3C;
      end
    end
    force_div = 1'b0;
    chk("drain_cycles", drain_cycles, PL);
    chk("drain_occupancy", occupancy, 0);
    chk("drain_overflowError", overflowError, 0);
    chk("drain_creditError", creditError, 0);

    // Fill to credit limit
    rdy_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (i > 0) @(negedge clk);
      if (issueReady) rdy_cnt++;
      issue      = m_ready;
      issue_data = W'(i);
    end
    @(negedge clk);
    issue = 1'b0;
    chk("fill_ready_cycles", rdy_cnt, D);
    repeat (PL + 1) @(negedge clk);
    chk("fill_occupancy", occupancy, D);
    chk("fill_credits", credits, D);
    chk("fill_overflowError", overflowError, 0);
    chk("fill_issueReady", issueReady, 0);
    chk("fill_head", dataOut, 0);

    // Pop alone at the credit limit frees a slot next cycle
    dataOutReady = 1'b1;
    @(negedge clk);
    dataOutReady = 1'b0;
    chk("pop_credits", credits, D - 1);
    chk("pop_issueReady", issueReady, 1);

    // Simultaneous issue and pop keeps credits
    issue = 1'b1; issue_data = 8'h77; dataOutReady = 1'b1;
    @(negedge clk);
    issue = 1'b0; dataOutReady = 1'b0;
    chk("issue_pop_credits", credits, D - 1);
    chk("issue_pop_occupancy", occupancy, D - 2);

    issue = 1'b1; issue_data = 8'h78;
    @(negedge clk);
    issue = 1'b0;
    chk("refill_credits", credits, D);
    repeat (PL + 1) @(negedge clk);
    chk("refill_occupancy", occupancy, D);
    chk("refill_overflowError", overflowError, 0);

    // Issue while not ready
    issue = 1'b1; issue_data = 8'h99;
    @(negedge clk);
    issue = 1'b0;
    chk("cerr_flag", creditError, 1);
    chk("cerr_credits", credits, D);

    // Forced arrival when full, no pop: dropped
    force_div = 1'b1; force_data = 8'h5A;
    @(negedge clk);
    force_div = 1'b0;
    chk("ovf_occupancy", occupancy, D);
    chk("ovf_flag", overflowError, 1);

    // Forced arrival when full with a pop: accepted
    force_div = 1'b1; force_data = 8'hA5; dataOutReady = 1'b1;
    @(negedge clk);
    force_div = 1'b0; dataOutReady = 1'b0;
    chk("full_pop_push_occupancy", occupancy, D);

    repeat (3) @(negedge clk);
    chk("sticky_creditError", creditError, 1);
    chk("sticky_overflowError", overflowError, 1);

    dataOutReady = 1'b1;
    repeat (D + 2) @(negedge clk);
    dataOutReady = 1'b0;

    // Reset clears sticky flags; streaming
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (PL) @(negedge clk);
    chk("rerun_issueReady", issueReady, 1);
    chk("rerun_creditError", creditError, 0);
    chk("rerun_overflowError", overflowError, 0);

    dataOutReady = 1'b1;
    exp_idx  = 0;
    max_cred = 0;
    for (int i = 0; i < 100 + PL + 3; i++) begin
      if (i > 0) @(negedge clk);
      if (dataOutValid) begin
        chk("stream_data", dataOut, exp_idx);
        exp_idx++;
      end
      if (int'(credits) > max_cred) max_cred = int'(credits);
      issue      = (i < 100) && m_ready;
      issue_data = W'(i);
    end
    issue = 1'b0;
    @(negedge clk);
    chk("stream_count", exp_idx, 100);
    chk("stream_max_credits_le5", max_cred <= 5, 1);
    chk("stream_creditError", creditError, 0);
    chk("stream_overflowError", overflowError, 0);

    // Random legal traffic
    for (int i = 0; i < 500; i++) begin
      issue        = ($urandom_range(0, 9) < 7) && m_ready;
      issue_data   = W'($urandom_range(0, 255));
      dataOutReady = $urandom_range(0, 1) != 0;
      @(negedge clk);
    end
    issue = 1'b0;

    // Reset mid-stream with 7 stored and 3 in flight
    dataOutReady = 1'b1;
    repeat (D + PL + 2) @(negedge clk);
    dataOutReady = 1'b0;
    for (int i = 0; i < 7; i++) begin
      issue = 1'b1; issue_data = W'(8'h40 + i);
      @(negedge clk);
    end
    issue = 1'b0;
    repeat (PL + 1) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      issue = 1'b1; issue_data = W'(8'h50 + i);
      @(negedge clk);
    end
    issue = 1'b0;
    chk("mid_occupancy", occupancy, 7);
    chk("mid_credits", credits, 10);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (PL) @(negedge clk);
    chk("post_rst_occupancy", occupancy, 0);
    chk("post_rst_credits", credits, 0);
    chk("post_rst_issueReady", issueReady, 1);
    chk("post_rst_overflowError", overflowError, 0);
    repeat (3) @(negedge clk);

    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
